// File: rtl/reservation_pkg.sv
// Shared types for the block allocator: block id width, counts, FSM states, skid entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reservation_pkg;

    localparam int BLOCK_COUNT_BITS = 4;
    localparam int BLOCK_COUNT      = 2 ** BLOCK_COUNT_BITS;

    typedef logic [BLOCK_COUNT_BITS-1:0] block_id_t;
    // One extra bit so the count can represent BLOCK_COUNT itself.
    typedef logic [BLOCK_COUNT_BITS:0]   block_cnt_t;

    localparam block_cnt_t FULL_COUNT = block_cnt_t'(BLOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ALLOC,
        DRAIN
    } alloc_state_e;

    typedef struct packed {
        block_id_t id;
        logic      last;
    } id_entry_t;

endpackage

// File: rtl/block_alloc_ctrl_if.sv
// Allocation, id-stream and free channels between a client and block_alloc_ctrl.
// Latency: n/a (wires only).
// Backpressure: each channel is valid/ready; master drives requests, slave is the allocator.
interface block_alloc_ctrl_if #(parameter int MAX_BURST = 8);
    import reservation_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             alloc_req_valid;
    logic             alloc_req_ready;
    logic [CNT_W-1:0] alloc_req_count;
    logic             alloc_err;

    logic             id_valid;
    logic             id_ready;
    block_id_t        id_out;
    logic             id_last;

    logic             free_valid;
    logic             free_ready;
    block_id_t        free_id;
    logic             free_err;

    modport master (
        output alloc_req_valid, alloc_req_count, id_ready, free_valid, free_id,
        input  alloc_req_ready, alloc_err, id_valid, id_out, id_last, free_ready, free_err
    );

    modport slave (
        input  alloc_req_valid, alloc_req_count, id_ready, free_valid, free_id,
        output alloc_req_ready, alloc_err, id_valid, id_out, id_last, free_ready, free_err
    );

endinterface

// File: rtl/block_alloc_ctrl_skid.sv
// Two-entry valid/ready buffer for {id, last} between the free-list pop and the id consumer.
// Latency: 1 cycle from push to out_vld_o.
// Backpressure: has_space_o drops when both entries are held; out_dat_o stable while stalled.
module id_skid_buffer
    import reservation_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_vld_i,
    input  id_entry_t in_dat_i,
    output logic      has_space_o,
    output logic      empty_o,
    output logic      out_vld_o,
    input  logic      out_rdy_i,
    output id_entry_t out_dat_o
);

    id_entry_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       push;
    logic       pop;

    assign has_space_o = (cnt_q != 2'd2);
    assign empty_o     = (cnt_q == 2'd0);
    assign out_vld_o   = !empty_o;
    assign out_dat_o   = mem_q[rd_ptr_q];
    assign push        = in_vld_i && has_space_o;
    assign pop         = out_vld_o && out_rdy_i;

    // Circular two-slot storage with occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_dat_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/block_alloc_ctrl.sv
// All-or-nothing N-block allocator in front of a free-list FIFO; also returns freed ids to it.
// Latency: first pop the cycle after request accept, id_valid one cycle later, then 1 id/cycle.
// Backpressure: request held off outside IDLE; pops stall on full skid; free/pop share one port slot.
module block_alloc_ctrl
    import reservation_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    block_alloc_ctrl_if.slave  bus,
    output logic               fl_enqueue_o,
    output logic               fl_dequeue_o,
    output block_id_t          fl_freed_id_o,
    input  block_id_t          fl_new_id_i,
    input  logic               fl_full_i,
    input  logic               fl_empty_i,
    input  logic               fl_rdy_i,
    output block_cnt_t         free_count_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t MAX_C = cnt_t'(MAX_BURST);

    alloc_state_e state_q;
    cnt_t         remaining_q;
    block_cnt_t   free_count_q;
    block_cnt_t   free_count_d;
    logic         rr_q;          // 1: push wins the next contested slot
    logic         alloc_err_q;
    logic         free_err_q;

    logic         alloc_acc;
    logic         alloc_bad;
    logic         pop_elig;
    logic         push_elig;
    logic         pop_grant;
    logic         free_acc;
    logic         free_drop;
    logic         skid_has_space;
    logic         skid_empty;
    id_entry_t    skid_in;
    id_entry_t    skid_out;

    // Request checks: count must be in range and fully covered by unreserved ids.
    assign alloc_acc = bus.alloc_req_valid && (state_q == IDLE) && !rst;
    assign alloc_bad = (bus.alloc_req_count == '0)
                    || (bus.alloc_req_count > MAX_C)
                    || (block_cnt_t'(bus.alloc_req_count) > free_count_q);

    // Free-list slot arbitration; at most one of push/pop reaches the port per cycle.
    assign pop_elig  = (state_q == ALLOC) && fl_rdy_i && !fl_empty_i && skid_has_space && !rst;
    assign push_elig = bus.free_valid && fl_rdy_i && !rst;
    assign pop_grant = pop_elig && !(push_elig && rr_q);

    // The push slot is open unless a pop is pending and currently holds priority.
    assign bus.free_ready = fl_rdy_i && !rst && !(pop_elig && !rr_q);
    assign free_acc       = bus.free_valid && bus.free_ready;
    assign free_drop      = (free_count_q == FULL_COUNT) || fl_full_i;

    assign fl_enqueue_o  = free_acc && !free_drop;
    assign fl_dequeue_o  = pop_grant;
    assign fl_freed_id_o = bus.free_id;

    assign skid_in.id   = fl_new_id_i;
    assign skid_in.last = (remaining_q == cnt_t'(1));

    assign bus.alloc_req_ready = (state_q == IDLE) && !rst;
    assign bus.alloc_err       = alloc_err_q;
    assign bus.free_err        = free_err_q;
    assign bus.id_out          = skid_out.id;
    assign bus.id_last         = skid_out.last;
    assign free_count_o        = free_count_q;

    id_skid_buffer u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_vld_i    (pop_grant),
        .in_dat_i    (skid_in),
        .has_space_o (skid_has_space),
        .empty_o     (skid_empty),
        .out_vld_o   (bus.id_valid),
        .out_rdy_i   (bus.id_ready),
        .out_dat_o   (skid_out)
    );

    // Reservation happens at accept; an accepted free adds back in the same edge.
    always_comb begin
        free_count_d = free_count_q;
        if (alloc_acc && !alloc_bad) begin
            free_count_d = free_count_d - block_cnt_t'(bus.alloc_req_count);
        end
        if (fl_enqueue_o) begin
            free_count_d = free_count_d + block_cnt_t'(1);
        end
    end

    // Allocation FSM: accept request, pop `remaining` ids, then wait for the skid to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            alloc_err_q <= 1'b0;
        end else begin
            alloc_err_q <= alloc_acc && alloc_bad;
            case (state_q)
                IDLE: begin
                    if (alloc_acc && !alloc_bad) begin
                        remaining_q <= bus.alloc_req_count;
                        state_q     <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (pop_grant) begin
                        remaining_q <= remaining_q - cnt_t'(1);
                        if (remaining_q == cnt_t'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (skid_empty) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free accounting, round-robin pointer and free-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_count_q <= FULL_COUNT;
            rr_q         <= 1'b0;
            free_err_q   <= 1'b0;
        end else begin
            free_count_q <= free_count_d;
            free_err_q   <= free_acc && free_drop;
            if (pop_elig && push_elig) begin
                rr_q <= !rr_q;
            end
        end
    end

endmodule

// File: tb/tb_block_alloc_ctrl.sv
// Bench for block_alloc_ctrl with a behavioural 16-entry free-list FIFO and an id scoreboard.
// Latency: n/a.
// Backpressure: id_ready toggled in the contention scenario.
module tb_block_alloc_ctrl;
    import reservation_pkg::*;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_alloc_ctrl_if #(.MAX_BURST(8)) bus ();

    logic       fl_enqueue, fl_dequeue, fl_full, fl_empty, fl_rdy;
    block_id_t  fl_freed_id, fl_new_id;
    block_cnt_t free_count;

    block_alloc_ctrl #(.MAX_BURST(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .fl_enqueue_o  (fl_enqueue),
        .fl_dequeue_o  (fl_dequeue),
        .fl_freed_id_o (fl_freed_id),
        .fl_new_id_i   (fl_new_id),
        .fl_full_i     (fl_full),
        .fl_empty_i    (fl_empty),
        .fl_rdy_i      (fl_rdy),
        .free_count_o  (free_count)
    );

    // Free-list model: resets full holding ids 0..15 in order.
    block_id_t  fl_mem [BLOCK_COUNT];
    block_id_t  fl_head, fl_tail;
    block_cnt_t fl_cnt;

    assign fl_new_id = fl_mem[fl_head];
    assign fl_empty  = (fl_cnt == '0);
    assign fl_full   = (fl_cnt == FULL_COUNT);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_COUNT; i++) fl_mem[i] <= block_id_t'(i);
            fl_head <= '0;
            fl_tail <= '0;
            fl_cnt  <= FULL_COUNT;
        end else begin
            if (fl_enqueue) begin
                fl_mem[fl_tail] <= fl_freed_id;
                fl_tail         <= fl_tail + block_id_t'(1);
            end
            if (fl_dequeue) fl_head <= fl_head + block_id_t'(1);
            fl_cnt <= fl_cnt + block_cnt_t'(fl_enqueue) - block_cnt_t'(fl_dequeue);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard and event monitors, sampled on the falling edge.
    id_entry_t exp_q [$];
    int aerr_cnt = 0, ferr_cnt = 0, enq_cnt = 0, deq_cnt = 0;
    int both_cnt = 0, b2b_cnt = 0, stab_cnt = 0, rx_cnt = 0;
    logic prev_deq = 1'b0, prev_fv = 1'b0, stall_q = 1'b0, held_last = 1'b0;
    block_id_t held_id = '0;

    always @(negedge clk) begin
        id_entry_t e;
        if (!rst) begin
            if (bus.alloc_err) aerr_cnt++;
            if (bus.free_err)  ferr_cnt++;
            if (fl_enqueue)    enq_cnt++;
            if (fl_dequeue)    deq_cnt++;
            if (fl_enqueue && fl_dequeue) both_cnt++;
            if (fl_dequeue && prev_deq && bus.free_valid && prev_fv) b2b_cnt++;
            prev_deq = fl_dequeue;
            prev_fv  = bus.free_valid;
            if (stall_q && bus.id_valid && (bus.id_out !== held_id || bus.id_last !== held_last))
                stab_cnt++;
            stall_q   = bus.id_valid && !bus.id_ready;
            held_id   = bus.id_out;
            held_last = bus.id_last;
            if (bus.id_valid && bus.id_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_id", 32'(bus.id_out), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_out", 32'(bus.id_out), 32'(e.id));
                    chk("id_last", 32'(bus.id_last), 32'(e.last));
                end
            end
        end else begin
            prev_deq = 1'b0;
            prev_fv  = 1'b0;
            stall_q  = 1'b0;
        end
    end

    task automatic exp_range(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            id_entry_t e;
            e.id   = block_id_t'(first + k);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_alloc(input int n);
        int t;
        t = 0;
        bus.alloc_req_valid = 1'b1;
        bus.alloc_req_count = CNT_W'(n);
        @(negedge clk);
        while (!bus.alloc_req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.alloc_req_ready) chk("alloc_timeout", 0, 1);
        @(posedge clk);
        #1 bus.alloc_req_valid = 1'b0;
    endtask

    task automatic free_burst(input int first, input int n);
        int t;
        bus.free_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            bus.free_id = block_id_t'(first + k);
            t = 0;
            @(negedge clk);
            while (!bus.free_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!bus.free_ready) chk("free_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        bus.free_valid = 1'b0;
    endtask

    task automatic wait_sb(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, d0, e0, f0, r0, t;
        logic done5;
        bus.alloc_req_valid = 1'b0;
        bus.alloc_req_count = '0;
        bus.free_valid      = 1'b0;
        bus.free_id         = '0;
        bus.id_ready        = 1'b1;
        fl_rdy              = 1'b1;

        // Reset values, observed both inside and just after reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_idv", 32'(bus.id_valid), 0);
        chk("rst_in_rdy", 32'(bus.alloc_req_ready), 0);
        chk("rst_in_deq", 32'(fl_dequeue), 0);
        do_reset();
        @(negedge clk);
        chk("rst_fc", 32'(free_count), 16);
        chk("rst_idv", 32'(bus.id_valid), 0);
        chk("rst_rdy", 32'(bus.alloc_req_ready), 1);
        chk("rst_aerr", 32'(bus.alloc_err), 0);
        chk("rst_ferr", 32'(bus.free_err), 0);
        chk("rst_enq", 32'(fl_enqueue), 0);
        @(posedge clk);
        #1;

        // Alloc 3: pop in the cycle after accept, ids on consecutive cycles.
        r0 = rx_cnt;
        exp_range(0, 3);
        do_alloc(3);
        @(negedge clk);
        chk("t1_idv_early", 32'(bus.id_valid), 0);
        chk("t1_first_pop", 32'(fl_dequeue), 1);
        @(negedge clk);
        chk("t1_idv", 32'(bus.id_valid), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rate", 32'(rx_cnt - r0), 3);
        wait_sb(50);
        chk("t1_fc", 32'(free_count), 13);

        // Out-of-range counts rejected without touching the free list.
        a0 = aerr_cnt;
        d0 = deq_cnt;
        do_alloc(0);
        do_alloc(9);
        repeat (2) @(negedge clk);
        chk("t3_aerr", 32'(aerr_cnt - a0), 2);
        chk("t3_deq", 32'(deq_cnt - d0), 0);
        chk("t3_rdy", 32'(bus.alloc_req_ready), 1);
        chk("t3_fc", 32'(free_count), 13);
        @(posedge clk);
        #1;

        // Exhaust the pool with two bursts of 8, then an unfundable request.
        do_reset();
        exp_range(0, 8);
        do_alloc(8);
        exp_range(8, 8);
        do_alloc(8);
        wait_sb(100);
        chk("t2_fc", 32'(free_count), 0);
        a0 = aerr_cnt;
        do_alloc(1);
        repeat (2) @(negedge clk);
        chk("t2_aerr", 32'(aerr_cnt - a0), 1);
        chk("t2_fc_err", 32'(free_count), 0);
        @(posedge clk);
        #1;

        // Free id 5 and reallocate it.
        free_burst(5, 1);
        @(negedge clk);
        chk("t4_fc_free", 32'(free_count), 1);
        @(posedge clk);
        #1;
        exp_range(5, 1);
        do_alloc(1);
        wait_sb(50);
        chk("t4_fc", 32'(free_count), 0);

        // Free while every id is already free: dropped.
        do_reset();
        f0 = ferr_cnt;
        e0 = enq_cnt;
        free_burst(3, 1);
        repeat (2) @(negedge clk);
        chk("t4_ferr", 32'(ferr_cnt - f0), 1);
        chk("t4_enq", 32'(enq_cnt - e0), 0);
        chk("t4_fc_full", 32'(free_count), 16);
        @(posedge clk);
        #1;

        // Contention: alloc 4 against continuous frees with a toggling consumer.
        exp_range(0, 8);
        do_alloc(8);
        wait_sb(100);
        chk("t5_fc_pre", 32'(free_count), 8);
        e0 = enq_cnt;
        d0 = deq_cnt;
        exp_range(8, 4);
        done5 = 1'b0;
        fork
            begin
                fork
                    do_alloc(4);
                    free_burst(0, 4);
                join
                wait_sb(200);
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    @(posedge clk);
                    #1 bus.id_ready = ~bus.id_ready;
                end
            end
        join
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("t5_fc", 32'(free_count), 8);
        chk("t5_enq", 32'(enq_cnt - e0), 4);
        chk("t5_deq", 32'(deq_cnt - d0), 4);
        chk("t5_both", 32'(both_cnt), 0);
        chk("t5_rr", 32'(b2b_cnt), 0);
        chk("t5_stable", 32'(stab_cnt), 0);
        @(posedge clk);
        #1;

        // Reset in the middle of an alloc of 6.
        do_reset();
        exp_range(0, 6);
        r0 = rx_cnt;
        do_alloc(6);
        t = 0;
        while (rx_cnt < r0 + 2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (rx_cnt < r0 + 2) chk("t6_timeout", 32'(rx_cnt - r0), 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_idv", 32'(bus.id_valid), 0);
        chk("t6_rdy", 32'(bus.alloc_req_ready), 1);
        chk("t6_fc", 32'(free_count), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
